// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline-control logic: register index width,
// forwarding-select encoding and the instruction-type code tracked per slot.
package riscv_pkg;

    localparam int REG_WIDTH = 5;
    localparam int FWD_SEL_W = 3;

    localparam logic [FWD_SEL_W-1:0] FWD_RF = 3'd0;

    typedef enum logic {
        INSTR_OTHER = 1'b0,
        IS_LOAD     = 1'b1
    } instr_type_e;

    // Result of slot k is selected with code k+1.
    function automatic logic [FWD_SEL_W-1:0] fwd_slot(input logic [FWD_SEL_W-1:0] k);
        return k + 3'd1;
    endfunction

endpackage

// File: rtl/riscv_hazard_slot.sv
// One tracked pipeline slot: valid/rd/rde/type of an in-flight instruction,
// with a bubble input that turns the incoming entry into an empty slot.
module riscv_hazard_slot
    import riscv_pkg::*;
#(
    parameter int REG_WIDTH = riscv_pkg::REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_bubble,
    input  logic [REG_WIDTH-1:0] in_rd,
    input  logic                 in_rde,
    input  instr_type_e          in_type,
    output logic                 out_valid,
    output logic [REG_WIDTH-1:0] out_rd,
    output logic                 out_rde,
    output instr_type_e          out_type
);

    logic                 valid_d, valid_q;
    logic [REG_WIDTH-1:0] rd_d, rd_q;
    logic                 rde_d, rde_q;
    instr_type_e          type_d, type_q;

    always_comb begin
        valid_d = in_valid & ~in_bubble;
        rd_d    = in_rd;
        rde_d   = in_rde;
        type_d  = in_type;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            rde_q   <= 1'b0;
            type_q  <= INSTR_OTHER;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            rde_q   <= rde_d;
            type_q  <= type_d;
        end
    end

    assign out_valid = valid_q;
    assign out_rd    = rd_q;
    assign out_rde   = rde_q;
    assign out_type  = type_q;

endmodule

// File: rtl/riscv_hazard_unit.sv
// Pipeline hazard unit: tracks in-flight destinations from execute to RF write
// and derives stall, flush and per-operand forwarding selects for decode.
module riscv_hazard_unit
    import riscv_pkg::*;
#(
    parameter int REG_WIDTH = riscv_pkg::REG_WIDTH,
    parameter int STAGES    = 3,
    parameter int FWD_EN    = 1,
    parameter int LOAD_LAT  = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REG_WIDTH-1:0] id_rs1,
    input  logic                 id_rs1e,
    input  logic [REG_WIDTH-1:0] id_rs2,
    input  logic                 id_rs2e,
    input  logic [REG_WIDTH-1:0] id_rd,
    input  logic                 id_rde,
    input  logic                 id_is_load,
    input  logic                 ex_taken,
    output logic                 stall,
    output logic                 flush,
    output logic [FWD_SEL_W-1:0] fwd_sel1,
    output logic [FWD_SEL_W-1:0] fwd_sel2,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    localparam logic [FWD_SEL_W-1:0] LOAD_LAT_C = 3'(LOAD_LAT);

    logic                 slot_valid [STAGES];
    logic [REG_WIDTH-1:0] slot_rd    [STAGES];
    logic                 slot_rde   [STAGES];
    instr_type_e          slot_type  [STAGES];

    logic                 chain_valid  [STAGES];
    logic                 chain_bubble [STAGES];
    logic [REG_WIDTH-1:0] chain_rd     [STAGES];
    logic                 chain_rde    [STAGES];
    instr_type_e          chain_type   [STAGES];

    // Slot 0 is fed from decode; every other slot shifts from its younger neighbour.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_slot
            if (gi == 0) begin : g_head
                assign chain_valid[gi]  = id_valid;
                assign chain_bubble[gi] = stall | flush;
                assign chain_rd[gi]     = id_rd;
                assign chain_rde[gi]    = id_rde;
                assign chain_type[gi]   = id_is_load ? IS_LOAD : INSTR_OTHER;
            end else begin : g_tail
                assign chain_valid[gi]  = slot_valid[gi-1];
                assign chain_bubble[gi] = 1'b0;
                assign chain_rd[gi]     = slot_rd[gi-1];
                assign chain_rde[gi]    = slot_rde[gi-1];
                assign chain_type[gi]   = slot_type[gi-1];
            end

            riscv_hazard_slot #(
                .REG_WIDTH (REG_WIDTH)
            ) u_slot (
                .clk       (clk),
                .reset     (reset),
                .in_valid  (chain_valid[gi]),
                .in_bubble (chain_bubble[gi]),
                .in_rd     (chain_rd[gi]),
                .in_rde    (chain_rde[gi]),
                .in_type   (chain_type[gi]),
                .out_valid (slot_valid[gi]),
                .out_rd    (slot_rd[gi]),
                .out_rde   (slot_rde[gi]),
                .out_type  (slot_type[gi])
            );
        end
    endgenerate

    logic                 hit1, hit2;
    logic [FWD_SEL_W-1:0] idx1, idx2;
    logic                 op1_stall, op2_stall;

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        idx1 = '0;
        idx2 = '0;
        // Scan oldest to youngest so the youngest producer is the last one kept.
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (slot_valid[k] && slot_rde[k] && slot_rd[k] == id_rs1) begin
                hit1 = 1'b1;
                idx1 = 3'(k);
            end
            if (slot_valid[k] && slot_rde[k] && slot_rd[k] == id_rs2) begin
                hit2 = 1'b1;
                idx2 = 3'(k);
            end
        end
        hit1 = hit1 & id_rs1e & (id_rs1 != '0);
        hit2 = hit2 & id_rs2e & (id_rs2 != '0);

        if (FWD_EN != 0) begin
            op1_stall = hit1 & (slot_type[idx1] == IS_LOAD) & (idx1 < LOAD_LAT_C);
            op2_stall = hit2 & (slot_type[idx2] == IS_LOAD) & (idx2 < LOAD_LAT_C);
            fwd_sel1  = (hit1 && !op1_stall) ? fwd_slot(idx1) : FWD_RF;
            fwd_sel2  = (hit2 && !op2_stall) ? fwd_slot(idx2) : FWD_RF;
        end else begin
            op1_stall = hit1;
            op2_stall = hit2;
            fwd_sel1  = FWD_RF;
            fwd_sel2  = FWD_RF;
        end

        flush = ex_taken;
        stall = id_valid & (op1_stall | op2_stall) & ~ex_taken;
    end

    logic [CNT_WIDTH-1:0] stall_cnt_d, stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Bench for riscv_hazard_unit: a forwarding instance and a stall-only instance,
// each checked every cycle against a list-of-in-flight-writes model.
module tb_riscv_hazard_unit;

    localparam int STG = 3;
    localparam int LAT = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid [2];
    logic [4:0] id_rs1   [2];
    logic       id_rs1e  [2];
    logic [4:0] id_rs2   [2];
    logic       id_rs2e  [2];
    logic [4:0] id_rd    [2];
    logic       id_rde   [2];
    logic       id_ld    [2];
    logic       ex_taken [2];

    logic       stall_o [2];
    logic       flush_o [2];
    logic [2:0] sel1_o  [2];
    logic [2:0] sel2_o  [2];
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_hazard_unit #(
        .REG_WIDTH(5), .STAGES(STG), .FWD_EN(1), .LOAD_LAT(LAT), .CNT_WIDTH(16)
    ) dut_fwd (
        .clk(clk), .reset(reset),
        .id_valid(id_valid[0]), .id_rs1(id_rs1[0]), .id_rs1e(id_rs1e[0]),
        .id_rs2(id_rs2[0]), .id_rs2e(id_rs2e[0]), .id_rd(id_rd[0]), .id_rde(id_rde[0]),
        .id_is_load(id_ld[0]), .ex_taken(ex_taken[0]),
        .stall(stall_o[0]), .flush(flush_o[0]), .fwd_sel1(sel1_o[0]), .fwd_sel2(sel2_o[0]),
        .stall_cnt(cnt0)
    );

    riscv_hazard_unit #(
        .REG_WIDTH(5), .STAGES(STG), .FWD_EN(0), .LOAD_LAT(LAT), .CNT_WIDTH(2)
    ) dut_stl (
        .clk(clk), .reset(reset),
        .id_valid(id_valid[1]), .id_rs1(id_rs1[1]), .id_rs1e(id_rs1e[1]),
        .id_rs2(id_rs2[1]), .id_rs2e(id_rs2e[1]), .id_rd(id_rd[1]), .id_rde(id_rde[1]),
        .id_is_load(id_ld[1]), .ex_taken(ex_taken[1]),
        .stall(stall_o[1]), .flush(flush_o[1]), .fwd_sel1(sel1_o[1]), .fwd_sel2(sel2_o[1]),
        .stall_cnt(cnt1)
    );

    // Model: per unit, the list of writes in flight (index 0 = youngest) plus a counter.
    int m_valid [2][STG];
    int m_rd    [2][STG];
    int m_rde   [2][STG];
    int m_ld    [2][STG];
    int m_cnt   [2];
    int m_fwd   [2] = '{1, 0};
    int m_max   [2] = '{65535, 3};

    function automatic int youngest(input int u, input int rs, input int en);
        if (en == 0 || rs == 0) return -1;
        for (int k = 0; k < STG; k++)
            if (m_valid[u][k] != 0 && m_rde[u][k] != 0 && m_rd[u][k] == rs) return k;
        return -1;
    endfunction

    function automatic int op_stall(input int u, input int k);
        if (k < 0) return 0;
        if (m_fwd[u] == 0) return 1;
        return (m_ld[u][k] != 0 && k < LAT) ? 1 : 0;
    endfunction

    function automatic int exp_sel(input int u, input int rs, input int en);
        int k;
        k = youngest(u, rs, en);
        if (m_fwd[u] == 0 || k < 0 || op_stall(u, k) != 0) return 0;
        return k + 1;
    endfunction

    function automatic int exp_stall(input int u);
        int s;
        s = op_stall(u, youngest(u, int'(id_rs1[u]), int'(id_rs1e[u])))
          | op_stall(u, youngest(u, int'(id_rs2[u]), int'(id_rs2e[u])));
        return (id_valid[u] && s != 0 && !ex_taken[u]) ? 1 : 0;
    endfunction

    function automatic int dut_cnt(input int u);
        return (u == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                for (int u = 0; u < 2; u++) begin
                    m_cnt[u] = 0;
                    for (int k = 0; k < STG; k++) begin
                        m_valid[u][k] = 0; m_rd[u][k] = 0; m_rde[u][k] = 0; m_ld[u][k] = 0;
                    end
                end
            end else begin
                for (int u = 0; u < 2; u++) begin
                    int st;
                    st = exp_stall(u);
                    if (st != 0 && m_cnt[u] < m_max[u]) m_cnt[u]++;
                    for (int k = STG - 1; k > 0; k--) begin
                        m_valid[u][k] = m_valid[u][k-1]; m_rd[u][k] = m_rd[u][k-1];
                        m_rde[u][k]   = m_rde[u][k-1];   m_ld[u][k] = m_ld[u][k-1];
                    end
                    m_valid[u][0] = (id_valid[u] && st == 0 && !ex_taken[u]) ? 1 : 0;
                    m_rd[u][0]    = int'(id_rd[u]);
                    m_rde[u][0]   = int'(id_rde[u]);
                    m_ld[u][0]    = int'(id_ld[u]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                chk($sformatf("u%0d_stall", u), int'(stall_o[u]), exp_stall(u));
                chk($sformatf("u%0d_flush", u), int'(flush_o[u]), int'(ex_taken[u]));
                chk($sformatf("u%0d_sel1", u), int'(sel1_o[u]), exp_sel(u, int'(id_rs1[u]), int'(id_rs1e[u])));
                chk($sformatf("u%0d_sel2", u), int'(sel2_o[u]), exp_sel(u, int'(id_rs2[u]), int'(id_rs2e[u])));
                chk($sformatf("u%0d_cnt", u), dut_cnt(u), m_cnt[u]);
            end
        end
    end

    task automatic set_in(input int u, input int v, input int rs1, input int e1, input int rs2,
                          input int e2, input int rd, input int rde, input int ld, input int tk);
        int o;
        o = 1 - u;
        id_valid[u] = 1'(v);  id_rs1[u] = 5'(rs1); id_rs1e[u] = 1'(e1);
        id_rs2[u]   = 5'(rs2); id_rs2e[u] = 1'(e2); id_rd[u]   = 5'(rd);
        id_rde[u]   = 1'(rde); id_ld[u]   = 1'(ld); ex_taken[u] = 1'(tk);
        id_valid[o] = 1'b0; id_rs1[o] = '0; id_rs1e[o] = 1'b0; id_rs2[o] = '0; id_rs2e[o] = 1'b0;
        id_rd[o] = '0; id_rde[o] = 1'b0; id_ld[o] = 1'b0; ex_taken[o] = 1'b0;
    endtask

    task automatic drive(input int u, input int v, input int rs1, input int e1, input int rs2,
                         input int e2, input int rd, input int rde, input int ld, input int tk);
        set_in(u, v, rs1, e1, rs2, e2, rd, rde, ld, tk);
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stall_run(input string name, input int exp_n);
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
            if (!stall_o[1]) break;
            n++;
            tick();
        end
        chk(name, n, exp_n);
        chk({name, "_sel1"}, int'(sel1_o[1]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        // Reset: candidate reads x5 but nothing is tracked
        drive(0, 1, 5, 1, 5, 1, 6, 1, 0, 0);
        chk("rst_stall", int'(stall_o[0]), 0);
        chk("rst_flush", int'(flush_o[0]), 0);
        chk("rst_sel1", int'(sel1_o[0]), 0);
        chk("rst_sel2", int'(sel2_o[0]), 0);
        chk("rst_cnt", int'(cnt0), 0);
        tick();
        reset = 1'b1;

        // ALU dependency with forwarding
        drive(0, 1, 1, 1, 2, 1, 5, 1, 0, 0); tick();           // add x5,x1,x2
        drive(0, 1, 5, 1, 7, 1, 6, 1, 0, 0);                    // add x6,x5,x7
        chk("alu_stall", int'(stall_o[0]), 0);
        chk("alu_sel1_k0", int'(sel1_o[0]), 1);
        tick();
        drive(0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        chk("alu_sel1_k1", int'(sel1_o[0]), 2);
        tick();
        drive(0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        chk("alu_sel1_k2", int'(sel1_o[0]), 3);
        tick();
        drive(0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        chk("alu_sel1_gone", int'(sel1_o[0]), 0);
        tick();

        // Load-use: exactly one stall cycle, then forward from slot 1
        drive(0, 1, 1, 1, 0, 0, 3, 1, 1, 0); tick();           // lw x3
        drive(0, 1, 3, 1, 3, 1, 4, 1, 0, 0);                    // add x4,x3,x3
        chk("ld_stall", int'(stall_o[0]), 1);
        tick();
        drive(0, 1, 3, 1, 3, 1, 4, 1, 0, 0);
        chk("ld_stall_rel", int'(stall_o[0]), 0);
        chk("ld_sel1", int'(sel1_o[0]), 2);
        chk("ld_sel2", int'(sel2_o[0]), 2);
        chk("ld_cnt", int'(cnt0), 1);
        tick();

        // x0 never matches
        drive(0, 1, 1, 1, 0, 0, 0, 1, 0, 0); tick();
        drive(0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        chk("x0_stall", int'(stall_o[0]), 0);
        chk("x0_sel1", int'(sel1_o[0]), 0);
        tick();

        // Youngest writer wins
        drive(0, 1, 1, 1, 0, 0, 9, 1, 0, 0); tick();
        drive(0, 1, 2, 1, 0, 0, 9, 1, 0, 0); tick();
        drive(0, 1, 0, 0, 9, 1, 0, 0, 0, 0);
        chk("young_sel2", int'(sel2_o[0]), 1);
        tick();

        // Flush beats load-use stall; the killed candidate (rd=x11) never enters slot 0
        drive(0, 1, 1, 1, 0, 0, 10, 1, 1, 0); tick();          // lw x10
        drive(0, 1, 10, 1, 0, 0, 11, 1, 0, 1);
        chk("fl_flush", int'(flush_o[0]), 1);
        chk("fl_stall", int'(stall_o[0]), 0);
        tick();
        drive(0, 1, 11, 1, 10, 1, 0, 0, 0, 0);
        chk("fl_killed_sel1", int'(sel1_o[0]), 0);
        chk("fl_load_sel2", int'(sel2_o[0]), 2);
        chk("fl_cnt", int'(cnt0), 1);
        tick();

        // Stall-only mode: three stall cycles, then counter saturates at 3
        drive(1, 1, 1, 1, 0, 0, 5, 1, 0, 0); tick();
        stall_run("so_stalls", 3);
        chk("so_cnt", int'(cnt1), 3);
        tick();
        drive(1, 1, 1, 1, 0, 0, 5, 1, 0, 0); tick();
        stall_run("so_stalls2", 3);
        chk("so_cnt_sat", int'(cnt1), 3);
        tick();

        // Asynchronous reset discards in-flight writes immediately
        drive(0, 1, 1, 1, 0, 0, 7, 1, 0, 0); tick();
        set_in(0, 1, 7, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("ar_pre_sel1", int'(sel1_o[0]), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_sel1", int'(sel1_o[0]), 0);
        chk("ar_cnt", int'(cnt0), 0);
        @(negedge clk);
        tick();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
